// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, zero-bubble handover
// and optional bounded-hold preemption for fairness.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit PREEMPT = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    others;
  logic [IW-1:0]   ptr_inc;
  logic            do_grant;
  logic [N-1:0]    pick_req;
  logic [IW-1:0]   pick_ptr;

  // Scans downward so the candidate closest to the pointer is the last (winning) write.
  function automatic logic [IW-1:0] pick_idx(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] res;
    int            idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx[IW-1:0]]) res = idx[IW-1:0];
    end
    return res;
  endfunction

  assign others  = req & ~gnt_q;
  assign ptr_inc = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    do_grant = 1'b0;
    pick_req = req;
    pick_ptr = ptr_q;

    case (state_q)
      IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      OWN: begin
        if (!req[gnt_id_q]) begin
          ptr_d = ptr_inc;
          if (|others) begin
            do_grant = 1'b1;
            pick_ptr = ptr_inc;
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            hold_d   = '0;
            state_d  = IDLE;
          end
        end else if (PREEMPT && hold_q == HOLD_LAST && |others) begin
          // The current owner is excluded so it drops to lowest priority.
          ptr_d    = ptr_inc;
          pick_req = others;
          pick_ptr = ptr_inc;
          do_grant = 1'b1;
        end else if (|others) begin
          if (PREEMPT && hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      gnt_id_d           = pick_idx(pick_req, pick_ptr);
      gnt_d              = '0;
      gnt_d[gnt_id_d]    = 1'b1;
      busy_d             = 1'b1;
      hold_d             = '0;
      state_d            = OWN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q) && (busy_q == |gnt_q));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios plus random traffic against
// an owner/pointer reference model, on a preempting and a non-preempting instance.
module tb_rr_onehot_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt8, gnt0;
  logic [1:0]   id8, id0;
  logic         busy8, busy0;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: index 0 -> MAX_HOLD=8, index 1 -> MAX_HOLD=0
  int m_owner[2];
  int m_ptr[2];
  int m_run[2];
  int m_hold[2] = '{8, 0};

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt8), .gnt_id(id8), .busy(busy8)
  );
  rr_onehot_arbiter #(.N(N), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .gnt_id(id0), .busy(busy0)
  );

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_run[k]   = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [N-1:0] oth;
    if (m_owner[k] < 0) begin
      m_owner[k] = pick(req, m_ptr[k]);
      m_run[k]   = 0;
    end else if (!req[m_owner[k]]) begin
      m_ptr[k]   = (m_owner[k] + 1) % N;
      m_owner[k] = pick(req, m_ptr[k]);
      m_run[k]   = 0;
    end else begin
      oth = req;
      oth[m_owner[k]] = 1'b0;
      if (oth == '0) begin
        m_run[k] = 0;
      end else if (m_hold[k] != 0 && m_run[k] + 1 == m_hold[k]) begin
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_owner[k] = pick(oth, m_ptr[k]);
        m_run[k]   = 0;
      end else begin
        m_run[k] = m_run[k] + 1;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt(input int k);
    logic [N-1:0] g;
    g = '0;
    if (m_owner[k] >= 0) g[m_owner[k]] = 1'b1;
    return g;
  endfunction

  function automatic logic [1:0] exp_id(input int k);
    return (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt8 !== 4'b0000) begin errors++; $display("FAIL reset_gnt8 got %b expected 0000", gnt8); end
    checks++; if (id8 !== 2'd0) begin errors++; $display("FAIL reset_id8 got %0d expected 0", id8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b expected 0", busy8); end
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL reset_gnt0 got %b expected 0000", gnt0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b expected 0", busy0); end
    $display("test_reset: gnt8=%b busy8=%b gnt0=%b busy0=%b", gnt8, busy8, gnt0, busy0);
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (gnt8 !== 4'b0001 || busy8 !== 1'b1 || id8 !== 2'd0) begin
        errors++; $display("FAIL single_hold cycle %0d got gnt=%b busy=%b id=%0d expected 0001/1/0", c, gnt8, busy8, id8);
      end
    end
    req = 4'b0000;
    tick();
    checks++; if (gnt8 !== 4'b0000 || busy8 !== 1'b0) begin
      errors++; $display("FAIL single_release got gnt=%b busy=%b expected 0000/0", gnt8, busy8);
    end
    $display("test_single: final gnt=%b busy=%b", gnt8, busy8);
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] want;
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < N; i++) begin
      want = '0;
      want[i] = 1'b1;
      checks++; if (gnt8 !== want || busy8 !== 1'b1) begin
        errors++; $display("FAIL simul_order step %0d got gnt=%b busy=%b expected %b/1", i, gnt8, busy8, want);
      end
      req[i] = 1'b0;
      tick();
    end
    checks++; if (gnt8 !== 4'b0000 || busy8 !== 1'b0) begin
      errors++; $display("FAIL simul_end got gnt=%b busy=%b expected 0000/0", gnt8, busy8);
    end
    $display("test_simultaneous: final gnt=%b", gnt8);
  endtask

  task automatic test_pointer();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (gnt8 !== 4'b0100) begin errors++; $display("FAIL ptr_owner2 got %b expected 0100", gnt8); end
    req = 4'b1011;
    tick();
    checks++; if (gnt8 !== 4'b1000 || id8 !== 2'd3) begin
      errors++; $display("FAIL ptr_next got gnt=%b id=%0d expected 1000/3", gnt8, id8);
    end
    req = 4'b0011;
    tick();
    checks++; if (gnt8 !== 4'b0001 || id8 !== 2'd0) begin
      errors++; $display("FAIL ptr_wrap got gnt=%b id=%0d expected 0001/0", gnt8, id8);
    end
    $display("test_pointer: final gnt=%b", gnt8);
  endtask

  task automatic test_preempt();
    int n;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0011;
    n = 0;
    while (gnt8 === 4'b0001 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL preempt_cycles got %0d expected 8", n); end
    checks++; if (gnt8 !== 4'b0010) begin errors++; $display("FAIL preempt_gnt got %b expected 0010", gnt8); end
    checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL preempt_nohold_inst got %b expected 0001", gnt0); end
    $display("test_preempt: owner0 cycles with req1 pending=%0d gnt=%b", n, gnt8);
  endtask

  task automatic test_no_preempt();
    int bad;
    do_reset();
    req = 4'b0011;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt0 !== 4'b0001) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL nopreempt_hold got %0d cycles off 0001 expected 0", bad); end
    req = 4'b0010;
    tick();
    checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL nopreempt_handover got %b expected 0010", gnt0); end
    $display("test_no_preempt: final gnt=%b", gnt0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (gnt8 !== 4'b0100) begin errors++; $display("FAIL rstmid_pre got %b expected 0100", gnt8); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (gnt8 !== 4'b0000 || busy8 !== 1'b0 || gnt0 !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async got gnt8=%b busy8=%b gnt0=%b expected 0000/0/0000", gnt8, busy8, gnt0);
    end
    req = 4'b1100;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (gnt8 !== 4'b0100 || id8 !== 2'd2) begin
      errors++; $display("FAIL rstmid_regrant got gnt=%b id=%0d expected 0100/2", gnt8, id8);
    end
    $display("test_reset_mid: regrant gnt=%b", gnt8);
  endtask

  task automatic test_random();
    int bad_start;
    do_reset();
    bad_start = errors;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      tick();
      checks++; if (gnt8 !== exp_gnt(0) || id8 !== exp_id(0) || busy8 !== (m_owner[0] >= 0)) begin
        errors++; $display("FAIL rand_hold8 cycle %0d req=%b got gnt=%b id=%0d busy=%b expected gnt=%b id=%0d",
                           c, req, gnt8, id8, busy8, exp_gnt(0), exp_id(0));
      end
      checks++; if (gnt0 !== exp_gnt(1) || id0 !== exp_id(1) || busy0 !== (m_owner[1] >= 0)) begin
        errors++; $display("FAIL rand_hold0 cycle %0d req=%b got gnt=%b id=%0d busy=%b expected gnt=%b id=%0d",
                           c, req, gnt0, id0, busy0, exp_gnt(1), exp_id(1));
      end
      checks++; if (!$onehot0(gnt8) || !$onehot0(gnt0)) begin
        errors++; $display("FAIL rand_onehot cycle %0d got gnt8=%b gnt0=%b expected at most one bit", c, gnt8, gnt0);
      end
    end
    $display("test_random: 3000 cycles, %0d new errors", errors - bad_start);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_pointer();
    test_preempt();
    test_no_preempt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
